pspin_host_direct_unit: RTL and testbench

PSPIN_HOST_DIRECT_UNIT -- requirements
Module: pspin_host_direct_unit

---
 rtl/pspin_host_direct_unit_if.sv | 89 ++++++++
 rtl/pspin_host_direct_unit.sv | 174 +++++++++++++++++
 tb/tb_pspin_host_direct_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pspin_host_direct_unit_if.sv
// Types and handshake bundle for the HostDirect unit: command in, AXI master out, completion out.
// Latency: none (type and signal definitions only).
// Backpressure: valid/ready on command, every AXI channel and the completion.
package pspin_hdu_pkg;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 4;

    localparam logic [1:0] CMD_HOST_DIRECT = 2'd2;
    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [1:0] RESP_OKAY       = 2'b00;

    typedef struct packed {
        logic [7:0]   cmd_id;
        logic [1:0]   cmd_type;
        logic [63:0]  host_addr;
        logic [511:0] imm_data;
        logic [6:0]   imm_data_size;
        logic         nic_to_host;
        logic         generate_event;
    } pspin_cmd_t;

    typedef struct packed {
        logic [7:0]   cmd_id;
        logic [511:0] imm_data;
    } pspin_cmd_resp_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [USER_W-1:0] user;
    } axi_ax_t;

    typedef struct packed {
        axi_ax_t           aw;
        logic              aw_valid;
        logic [511:0]      w_data;
        logic [63:0]       w_strb;
        logic              w_last;
        logic [USER_W-1:0] w_user;
        logic              w_valid;
        logic              b_ready;
        axi_ax_t           ar;
        logic              ar_valid;
        logic              r_ready;
    } host_req_t;

    typedef struct packed {
        logic            aw_ready;
        logic            w_ready;
        logic            b_valid;
        logic [1:0]      b_resp;
        logic [ID_W-1:0] b_id;
        logic            ar_ready;
        logic            r_valid;
        logic [511:0]    r_data;
        logic [1:0]      r_resp;
        logic            r_last;
        logic [ID_W-1:0] r_id;
    } host_resp_t;
endpackage

interface pspin_host_direct_unit_if;
    import pspin_hdu_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    pspin_cmd_t      cmd;
    host_req_t       host_req;
    host_resp_t      host_resp;
    logic            resp_valid;
    logic            resp_ready;
    pspin_cmd_resp_t resp;
    logic            err;

    // Unit side.
    modport master (
        input  cmd_valid, cmd, host_resp, resp_ready,
        output cmd_ready, host_req, resp_valid, resp, err
    );

    // Command source / host / completion sink side.
    modport slave (
        output cmd_valid, cmd, host_resp, resp_ready,
        input  cmd_ready, host_req, resp_valid, resp, err
    );
endinterface

// File: rtl/pspin_host_direct_unit.sv
// Executes one HostDirect command as a single 64-byte AXI beat (write or read) and returns a completion.
// Latency: accept -> AW/AR valid next cycle; B/R handshake -> completion valid next cycle.
// Backpressure: one command in flight; cmd_ready_o only in IDLE; completion held until resp_ready_i.
module pspin_host_direct_unit
    import pspin_hdu_pkg::*;
#(
    parameter int unsigned AXI_ID   = 0,
    parameter int unsigned AXI_USER = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  pspin_cmd_t      cmd_i,
    output host_req_t       host_req_o,
    input  host_resp_t      host_resp_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output pspin_cmd_resp_t resp_o,
    output logic            err_o
);
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cmd_id_q, cmd_id_d;
    logic [63:0]   host_addr_q, host_addr_d;
    logic [511:0]  imm_q, imm_d;
    logic [6:0]    size_q, size_d;
    logic          n2h_q, n2h_d;
    logic          gen_q, gen_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          err_q, err_d;

    logic          accept, cmd_ok;
    logic [5:0]    off, cmd_off;
    logic [7:0]    end_byte;
    logic [511:0]  rd_shift, rd_data;
    logic [63:0]   w_strb;
    logic          aw_fire, w_fire, b_fire, ar_fire, r_fire;

    // Response IDs and r_last carry no information with a single outstanding beat.
    logic unused_resp;
    assign unused_resp = ^{host_resp_i.b_id, host_resp_i.r_id, host_resp_i.r_last};

    assign accept  = (state_q == IDLE) && cmd_valid_i;
    assign aw_fire = host_req_o.aw_valid && host_resp_i.aw_ready;
    assign w_fire  = host_req_o.w_valid  && host_resp_i.w_ready;
    assign b_fire  = host_req_o.b_ready  && host_resp_i.b_valid;
    assign ar_fire = host_req_o.ar_valid && host_resp_i.ar_ready;
    assign r_fire  = host_req_o.r_ready  && host_resp_i.r_valid;

    // Command legality, byte lane strobes and read-data extraction.
    always_comb begin
        cmd_off  = cmd_i.host_addr[5:0];
        cmd_ok   = (cmd_i.cmd_type == CMD_HOST_DIRECT) && (cmd_i.imm_data_size != 7'd0)
                && (cmd_i.imm_data_size <= 7'd64)
                && (({2'b00, cmd_off} + {1'b0, cmd_i.imm_data_size}) <= 8'd64);
        off      = host_addr_q[5:0];
        end_byte = {2'b00, off} + {1'b0, size_q};
        rd_shift = host_resp_i.r_data >> {off, 3'b000};
        w_strb   = '0;
        rd_data  = '0;
        for (int i = 0; i < 64; i++) begin
            w_strb[i]        = (8'(i) >= {2'b00, off}) && (8'(i) < end_byte);
            rd_data[8*i +: 8] = (8'(i) < {1'b0, size_q}) ? rd_shift[8*i +: 8] : 8'h00;
        end
    end

    // State register and latched command fields.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_id_q    <= '0;
            host_addr_q <= '0;
            imm_q       <= '0;
            size_q      <= '0;
            n2h_q       <= 1'b0;
            gen_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_id_q    <= cmd_id_d;
            host_addr_q <= host_addr_d;
            imm_q       <= imm_d;
            size_q      <= size_d;
            n2h_q       <= n2h_d;
            gen_q       <= gen_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            err_q       <= err_d;
        end
    end

    // Next state; a rejected command skips all AXI traffic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (cmd_valid_i) begin
                        if (!cmd_ok)                state_d = cmd_i.generate_event ? RESP : IDLE;
                        else if (cmd_i.nic_to_host) state_d = WRITE;
                        else                        state_d = READ;
                    end
            WRITE:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WAIT_B;
            WAIT_B: if (b_fire) state_d = gen_q ? RESP : IDLE;
            READ:   if (ar_fire) state_d = WAIT_R;
            WAIT_R: if (r_fire) state_d = RESP;
            RESP:   if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the latched fields; err is a one-cycle pulse.
    always_comb begin
        cmd_id_d    = cmd_id_q;
        host_addr_d = host_addr_q;
        imm_d       = imm_q;
        size_d      = size_q;
        n2h_d       = n2h_q;
        gen_d       = gen_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        err_d       = 1'b0;
        if (accept) begin
            cmd_id_d    = cmd_i.cmd_id;
            host_addr_d = cmd_i.host_addr;
            imm_d       = cmd_ok ? cmd_i.imm_data : '0;
            size_d      = cmd_i.imm_data_size;
            n2h_d       = cmd_i.nic_to_host;
            gen_d       = cmd_i.generate_event;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            err_d       = !cmd_ok;
        end
        if (state_q == WRITE) begin
            aw_done_d = aw_done_q || aw_fire;
            w_done_d  = w_done_q || w_fire;
        end
        if (b_fire) begin
            imm_d = '0;
            err_d = host_resp_i.b_resp != RESP_OKAY;
        end
        if (r_fire) begin
            imm_d = rd_data;
            err_d = host_resp_i.r_resp != RESP_OKAY;
        end
    end

    // Outputs decoded from state; everything forced low while reset is asserted.
    always_comb begin
        host_req_o          = '0;
        host_req_o.aw.id    = ID_W'(AXI_ID);
        host_req_o.aw.addr  = {host_addr_q[63:6], 6'b0};
        host_req_o.aw.size  = 3'd6;
        host_req_o.aw.burst = BURST_INCR;
        host_req_o.aw.user  = USER_W'(AXI_USER);
        host_req_o.ar       = host_req_o.aw;
        host_req_o.w_data   = imm_q << {off, 3'b000};
        host_req_o.w_strb   = w_strb;
        host_req_o.w_last   = 1'b1;
        host_req_o.w_user   = USER_W'(AXI_USER);
        host_req_o.aw_valid = rst_ni && (state_q == WRITE) && n2h_q && !aw_done_q;
        host_req_o.w_valid  = rst_ni && (state_q == WRITE) && n2h_q && !w_done_q;
        host_req_o.b_ready  = rst_ni && (state_q == WAIT_B);
        host_req_o.ar_valid = rst_ni && (state_q == READ) && !n2h_q;
        host_req_o.r_ready  = rst_ni && (state_q == WAIT_R);
        cmd_ready_o         = rst_ni && (state_q == IDLE);
        resp_valid_o        = rst_ni && (state_q == RESP);
        resp_o              = resp_valid_o ? {cmd_id_q, imm_q} : '0;
        err_o               = rst_ni && err_q;
    end
endmodule

// File: tb/tb_pspin_host_direct_unit.sv
// Directed self-checking bench for pspin_host_direct_unit.
// Latency: checks exact cycle timing of AXI and completion handshakes.
// Backpressure: exercises split AW/W readiness and a stalled completion.
module tb_pspin_host_direct_unit;
    import pspin_hdu_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pspin_host_direct_unit_if hd_if ();

    pspin_host_direct_unit #(.AXI_ID(0), .AXI_USER(0)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (hd_if.cmd_valid),
        .cmd_ready_o  (hd_if.cmd_ready),
        .cmd_i        (hd_if.cmd),
        .host_req_o   (hd_if.host_req),
        .host_resp_i  (hd_if.host_resp),
        .resp_valid_o (hd_if.resp_valid),
        .resp_ready_i (hd_if.resp_ready),
        .resp_o       (hd_if.resp),
        .err_o        (hd_if.err)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic set_cmd(input logic [7:0] id, input logic [1:0] typ, input logic [63:0] addr,
                           input logic [511:0] imm, input logic [6:0] size, input logic n2h,
                           input logic gen);
        hd_if.cmd.cmd_id         = id;
        hd_if.cmd.cmd_type       = typ;
        hd_if.cmd.host_addr      = addr;
        hd_if.cmd.imm_data       = imm;
        hd_if.cmd.imm_data_size  = size;
        hd_if.cmd.nic_to_host    = n2h;
        hd_if.cmd.generate_event = gen;
        hd_if.cmd_valid          = 1'b1;
    endtask

    task automatic test_reset;
        logic [8:0] outs;
        hd_if.cmd_valid  = 1'b0;
        hd_if.cmd        = '0;
        hd_if.host_resp  = '0;
        hd_if.resp_ready = 1'b0;
        repeat (2) @(negedge clk_i);
        outs = {hd_if.cmd_ready, hd_if.host_req.aw_valid, hd_if.host_req.w_valid,
                hd_if.host_req.ar_valid, hd_if.host_req.b_ready, hd_if.host_req.r_ready,
                hd_if.resp_valid, hd_if.err, |hd_if.resp};
        checks++;
        if (outs !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 000000000", outs);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (hd_if.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", hd_if.cmd_ready);
        end
    endtask

    task automatic test_write;
        logic [511:0] exp_data;
        exp_data = 512'h1122334455667788;
        exp_data = exp_data << 32;
        set_cmd(8'h05, CMD_HOST_DIRECT, 64'h1000_0004, 512'h1122334455667788, 7'd8, 1'b1, 1'b1);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        checks++;
        if ({hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.ar_valid} !== 3'b110) begin
            errors++; $display("FAIL wr_valids: got %b required 110",
                {hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.ar_valid});
        end
        checks++;
        if (hd_if.host_req.aw.addr !== 64'h1000_0000) begin
            errors++; $display("FAIL wr_aw_addr: got %h required 0000000010000000", hd_if.host_req.aw.addr);
        end
        checks++;
        if ({hd_if.host_req.aw.len, hd_if.host_req.aw.size, hd_if.host_req.aw.burst, hd_if.host_req.w_last}
            !== {8'd0, 3'd6, 2'b01, 1'b1}) begin
            errors++; $display("FAIL wr_aw_attr: got len %0d size %0d burst %0d last %0d required 0 6 1 1",
                hd_if.host_req.aw.len, hd_if.host_req.aw.size, hd_if.host_req.aw.burst, hd_if.host_req.w_last);
        end
        checks++;
        if (hd_if.host_req.w_strb !== 64'h0000_0000_0000_0FF0) begin
            errors++; $display("FAIL wr_strb: got %h required 0000000000000ff0", hd_if.host_req.w_strb);
        end
        checks++;
        if (hd_if.host_req.w_data !== exp_data) begin
            errors++; $display("FAIL wr_data: got %h required %h", hd_if.host_req.w_data, exp_data);
        end
        hd_if.host_resp.aw_ready = 1'b1;
        hd_if.host_resp.w_ready  = 1'b1;
        @(negedge clk_i);
        hd_if.host_resp.aw_ready = 1'b0;
        hd_if.host_resp.w_ready  = 1'b0;
        checks++;
        if ({hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.b_ready} !== 3'b001) begin
            errors++; $display("FAIL wr_wait_b: got %b required 001",
                {hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.b_ready});
        end
        hd_if.host_resp.b_valid = 1'b1;
        hd_if.host_resp.b_resp  = 2'b00;
        @(negedge clk_i);
        hd_if.host_resp.b_valid = 1'b0;
        checks++;
        if ({hd_if.resp_valid, hd_if.err, hd_if.host_req.b_ready} !== 3'b100) begin
            errors++; $display("FAIL wr_resp_valid: got %b required 100",
                {hd_if.resp_valid, hd_if.err, hd_if.host_req.b_ready});
        end
        checks++;
        if (hd_if.resp !== {8'h05, 512'h0}) begin
            errors++; $display("FAIL wr_resp: got id %h imm %h required id 05 imm 0",
                hd_if.resp.cmd_id, hd_if.resp.imm_data);
        end
        hd_if.resp_ready = 1'b1;
        @(negedge clk_i);
        hd_if.resp_ready = 1'b0;
        checks++;
        if ({hd_if.resp_valid, hd_if.cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_back_idle: got %b required 01", {hd_if.resp_valid, hd_if.cmd_ready});
        end
    endtask

    task automatic test_read;
        set_cmd(8'h09, CMD_HOST_DIRECT, 64'h2000_003C, 512'hABCD, 7'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        checks++;
        if ({hd_if.host_req.ar_valid, hd_if.host_req.aw_valid, hd_if.host_req.w_valid} !== 3'b100) begin
            errors++; $display("FAIL rd_valids: got %b required 100",
                {hd_if.host_req.ar_valid, hd_if.host_req.aw_valid, hd_if.host_req.w_valid});
        end
        checks++;
        if ({hd_if.host_req.ar.addr, hd_if.host_req.ar.len, hd_if.host_req.ar.size, hd_if.host_req.ar.burst}
            !== {64'h2000_0000, 8'd0, 3'd6, 2'b01}) begin
            errors++; $display("FAIL rd_ar: got addr %h len %0d size %0d burst %0d required 20000000 0 6 1",
                hd_if.host_req.ar.addr, hd_if.host_req.ar.len, hd_if.host_req.ar.size, hd_if.host_req.ar.burst);
        end
        hd_if.host_resp.ar_ready = 1'b1;
        @(negedge clk_i);
        hd_if.host_resp.ar_ready = 1'b0;
        checks++;
        if ({hd_if.host_req.ar_valid, hd_if.host_req.r_ready} !== 2'b01) begin
            errors++; $display("FAIL rd_wait_r: got %b required 01", {hd_if.host_req.ar_valid, hd_if.host_req.r_ready});
        end
        hd_if.host_resp.r_valid = 1'b1;
        hd_if.host_resp.r_resp  = 2'b00;
        hd_if.host_resp.r_data  = {32'hDEADBEEF, {60{8'h55}}};
        @(negedge clk_i);
        hd_if.host_resp.r_valid = 1'b0;
        checks++;
        if ({hd_if.resp_valid, hd_if.err} !== 2'b10) begin
            errors++; $display("FAIL rd_resp_valid: got %b required 10", {hd_if.resp_valid, hd_if.err});
        end
        checks++;
        if (hd_if.resp !== {8'h09, 512'hDEADBEEF}) begin
            errors++; $display("FAIL rd_resp: got id %h imm %h required id 09 imm deadbeef",
                hd_if.resp.cmd_id, hd_if.resp.imm_data);
        end
        hd_if.resp_ready = 1'b1;
        @(negedge clk_i);
        hd_if.resp_ready = 1'b0;
    endtask

    task automatic test_read_mask;
        logic [63:0]  addrs [2];
        logic [6:0]   sizes [2];
        logic [511:0] exps  [2];
        logic [511:0] rdat;
        addrs = '{64'h40, 64'h83};
        sizes = '{7'd2, 7'd3};
        exps  = '{512'h0302, 512'h050403};
        for (int i = 0; i < 64; i++) rdat[8*i +: 8] = 8'(i + 2);
        exps[1] = 512'h070605;
        for (int k = 0; k < 2; k++) begin
            set_cmd(8'(k + 16), CMD_HOST_DIRECT, addrs[k], '0, sizes[k], 1'b0, 1'b1);
            @(negedge clk_i);
            hd_if.cmd_valid = 1'b0;
            hd_if.host_resp.ar_ready = 1'b1;
            @(negedge clk_i);
            hd_if.host_resp.ar_ready = 1'b0;
            hd_if.host_resp.r_valid  = 1'b1;
            hd_if.host_resp.r_data   = rdat;
            @(negedge clk_i);
            hd_if.host_resp.r_valid = 1'b0;
            checks++;
            if (hd_if.resp.imm_data !== exps[k]) begin
                errors++; $display("FAIL rd_mask_%0d: got %h required %h", k, hd_if.resp.imm_data, exps[k]);
            end
            hd_if.resp_ready = 1'b1;
            @(negedge clk_i);
            hd_if.resp_ready = 1'b0;
        end
    endtask

    task automatic test_reject;
        set_cmd(8'h33, CMD_HOST_DIRECT, 64'h3000_003C, 512'hFFFF, 7'd8, 1'b1, 1'b1);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        checks++;
        if ({hd_if.err, hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.ar_valid,
             hd_if.resp_valid} !== 5'b10001) begin
            errors++; $display("FAIL rej_gen: got %b required 10001", {hd_if.err, hd_if.host_req.aw_valid,
                hd_if.host_req.w_valid, hd_if.host_req.ar_valid, hd_if.resp_valid});
        end
        checks++;
        if (hd_if.resp !== {8'h33, 512'h0}) begin
            errors++; $display("FAIL rej_resp: got id %h imm %h required id 33 imm 0",
                hd_if.resp.cmd_id, hd_if.resp.imm_data);
        end
        @(negedge clk_i);
        checks++;
        if ({hd_if.err, hd_if.resp_valid} !== 2'b01) begin
            errors++; $display("FAIL rej_pulse: got %b required 01", {hd_if.err, hd_if.resp_valid});
        end
        hd_if.resp_ready = 1'b1;
        @(negedge clk_i);
        hd_if.resp_ready = 1'b0;
        set_cmd(8'h34, 2'd0, 64'h0, 512'h1, 7'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        checks++;
        if ({hd_if.err, hd_if.resp_valid, hd_if.cmd_ready, hd_if.host_req.ar_valid} !== 4'b1010) begin
            errors++; $display("FAIL rej_nogen: got %b required 1010",
                {hd_if.err, hd_if.resp_valid, hd_if.cmd_ready, hd_if.host_req.ar_valid});
        end
        set_cmd(8'h35, CMD_HOST_DIRECT, 64'h0, 512'h1, 7'd0, 1'b1, 1'b0);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        checks++;
        if ({hd_if.err, hd_if.host_req.aw_valid, hd_if.cmd_ready} !== 3'b101) begin
            errors++; $display("FAIL rej_size0: got %b required 101",
                {hd_if.err, hd_if.host_req.aw_valid, hd_if.cmd_ready});
        end
        @(negedge clk_i);
    endtask

    task automatic test_aw_before_w;
        set_cmd(8'h41, CMD_HOST_DIRECT, 64'h5000_0000, 512'h0A0B, 7'd64, 1'b1, 1'b0);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        checks++;
        if (hd_if.host_req.w_strb !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL split_strb: got %h required ffffffffffffffff", hd_if.host_req.w_strb);
        end
        hd_if.host_resp.aw_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            hd_if.host_resp.aw_ready = 1'b0;
            checks++;
            if ({hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.b_ready} !== 3'b010) begin
                errors++; $display("FAIL split_hold_%0d: got %b required 010", c,
                    {hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.b_ready});
            end
        end
        hd_if.host_resp.w_ready = 1'b1;
        @(negedge clk_i);
        hd_if.host_resp.w_ready = 1'b0;
        checks++;
        if ({hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.b_ready} !== 3'b001) begin
            errors++; $display("FAIL split_wait_b: got %b required 001",
                {hd_if.host_req.aw_valid, hd_if.host_req.w_valid, hd_if.host_req.b_ready});
        end
        hd_if.host_resp.b_valid = 1'b1;
        @(negedge clk_i);
        hd_if.host_resp.b_valid = 1'b0;
        checks++;
        if ({hd_if.resp_valid, hd_if.cmd_ready, hd_if.host_req.b_ready} !== 3'b010) begin
            errors++; $display("FAIL split_no_resp: got %b required 010",
                {hd_if.resp_valid, hd_if.cmd_ready, hd_if.host_req.b_ready});
        end
    endtask

    task automatic test_backpressure_slverr;
        set_cmd(8'h77, CMD_HOST_DIRECT, 64'h6000_0010, 512'hBEEF, 7'd2, 1'b1, 1'b1);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        hd_if.host_resp.aw_ready = 1'b1;
        hd_if.host_resp.w_ready  = 1'b1;
        @(negedge clk_i);
        hd_if.host_resp.aw_ready = 1'b0;
        hd_if.host_resp.w_ready  = 1'b0;
        hd_if.host_resp.b_valid  = 1'b1;
        hd_if.host_resp.b_resp   = 2'b10;
        @(negedge clk_i);
        hd_if.host_resp.b_valid = 1'b0;
        hd_if.host_resp.b_resp  = 2'b00;
        checks++;
        if ({hd_if.err, hd_if.resp_valid} !== 2'b11) begin
            errors++; $display("FAIL slverr_pulse: got %b required 11", {hd_if.err, hd_if.resp_valid});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if ({hd_if.resp_valid, hd_if.cmd_ready, hd_if.err, hd_if.resp} !== {3'b100, 8'h77, 512'h0}) begin
                errors++; $display("FAIL bp_stable_%0d: got v%b r%b e%b id %h required v1 r0 e0 id 77", c,
                    hd_if.resp_valid, hd_if.cmd_ready, hd_if.err, hd_if.resp.cmd_id);
            end
        end
        hd_if.resp_ready = 1'b1;
        @(negedge clk_i);
        hd_if.resp_ready = 1'b0;
        checks++;
        if ({hd_if.resp_valid, hd_if.cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got %b required 01", {hd_if.resp_valid, hd_if.cmd_ready});
        end
    endtask

    task automatic test_reset_mid_read;
        set_cmd(8'h88, CMD_HOST_DIRECT, 64'h7000_0000, '0, 7'd4, 1'b0, 1'b1);
        @(negedge clk_i);
        hd_if.cmd_valid = 1'b0;
        hd_if.host_resp.ar_ready = 1'b1;
        @(negedge clk_i);
        hd_if.host_resp.ar_ready = 1'b0;
        checks++;
        if (hd_if.host_req.r_ready !== 1'b1) begin
            errors++; $display("FAIL mid_wait_r: got %b required 1", hd_if.host_req.r_ready);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({hd_if.host_req.r_ready, hd_if.cmd_ready, hd_if.resp_valid} !== 3'b000) begin
            errors++; $display("FAIL mid_in_reset: got %b required 000",
                {hd_if.host_req.r_ready, hd_if.cmd_ready, hd_if.resp_valid});
        end
        rst_ni = 1'b1;
        hd_if.host_resp.r_valid = 1'b1;
        hd_if.host_resp.r_data  = 512'h1234;
        @(negedge clk_i);
        hd_if.host_resp.r_valid = 1'b0;
        checks++;
        if ({hd_if.cmd_ready, hd_if.host_req.r_ready, hd_if.resp_valid} !== 3'b100) begin
            errors++; $display("FAIL mid_idle: got %b required 100",
                {hd_if.cmd_ready, hd_if.host_req.r_ready, hd_if.resp_valid});
        end
        @(negedge clk_i);
        checks++;
        if ({hd_if.resp_valid, hd_if.err} !== 2'b00) begin
            errors++; $display("FAIL mid_no_resp: got %b required 00", {hd_if.resp_valid, hd_if.err});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_mask();
        test_reject();
        test_aw_before_w();
        test_backpressure_slverr();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
